// File: rtl/alu_mdu_controller_if.sv
// EX-stage control bus between the pipeline and the ALU/MDU controller.
// The pipeline side is the master; the controller is the slave.
interface alu_mdu_controller_if #(
    parameter int OP_W = 5
);
    logic            in_valid;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            rtype;
    logic            rs2_zero;
    logic            flush;
    logic [OP_W-1:0] Operation;
    logic            illegal;
    logic            mdu_start;
    logic [2:0]      mdu_op;
    logic            mdu_kill;
    logic            stall;
    logic            result_sel;

    modport master (
        output in_valid, ALUOp, Funct7, Funct3, rtype, rs2_zero, flush,
        input  Operation, illegal, mdu_start, mdu_op, mdu_kill, stall, result_sel
    );
    modport slave (
        input  in_valid, ALUOp, Funct7, Funct3, rtype, rs2_zero, flush,
        output Operation, illegal, mdu_start, mdu_op, mdu_kill, stall, result_sel
    );
endinterface

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU operation decoder with RV32M detection and a start/kill
// sequencer for an external multi-cycle MDU, stalling the pipeline while busy.
module alu_mdu_controller #(
    parameter int OP_W     = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_mdu_controller_if.slave  bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

    localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_ADD  = 5'b00010,
                           OP_XOR  = 5'b00011, OP_SUB  = 5'b00100, OP_SRA  = 5'b00101,
                           OP_SLL  = 5'b00110, OP_SRL  = 5'b00111, OP_BEQ  = 5'b01000,
                           OP_BLT  = 5'b01001, OP_BGE  = 5'b01010, OP_BNE  = 5'b01011,
                           OP_BLTU = 5'b01100, OP_BGEU = 5'b01101, OP_SLT  = 5'b01110,
                           OP_JAL  = 5'b01111, OP_MDU  = 5'b10000, OP_SLTU = 5'b10001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_m1;
    logic [4:0]      code;
    logic [OP_W-1:0] op;
    logic            ill;
    logic            f7_base, f7_alt, m_enc, mop, launch;
    logic            start_q, kill_q, rsel_q;
    logic [2:0]      mdu_op_q;

    assign f7_base = bus.Funct7 == 7'b0000000;
    assign f7_alt  = bus.Funct7 == 7'b0100000;
    assign m_enc   = bus.ALUOp == 2'b10 && bus.rtype && bus.Funct7 == 7'b0000001;
    assign mop     = bus.in_valid && m_enc && (ENABLE_M != 0);
    assign launch  = state == IDLE && mop && !bus.flush;

    // Decode is independent of in_valid and FSM state.
    always_comb begin
        code = OP_ADD;
        ill  = 1'b0;
        case (bus.ALUOp)
            2'b00: code = OP_ADD;
            2'b01: begin
                case (bus.Funct3)
                    3'b000:  code = OP_BEQ;
                    3'b001:  code = OP_BNE;
                    3'b100:  code = OP_BLT;
                    3'b101:  code = OP_BGE;
                    3'b110:  code = OP_BLTU;
                    3'b111:  code = OP_BGEU;
                    default: ill  = 1'b1;
                endcase
            end
            2'b11: code = (bus.Funct3 == 3'b000) ? OP_ADD : OP_JAL;
            default: begin
                if (m_enc) begin
                    if (ENABLE_M != 0) code = OP_MDU;
                    else               ill  = 1'b1;
                end else if (bus.rtype && !f7_base && !f7_alt) begin
                    ill = 1'b1;
                end else begin
                    case (bus.Funct3)
                        3'b000: code = (bus.rtype && f7_alt) ? OP_SUB : OP_ADD;
                        3'b001: if (f7_base) code = OP_SLL; else ill = 1'b1;
                        3'b010: code = OP_SLT;
                        3'b011: code = OP_SLTU;
                        3'b100: code = OP_XOR;
                        3'b101: begin
                            if (f7_base)     code = OP_SRL;
                            else if (f7_alt) code = OP_SRA;
                            else             ill  = 1'b1;
                        end
                        3'b110: code = OP_OR;
                        default: code = OP_AND;
                    endcase
                end
            end
        endcase
        op      = '0;
        op[4:0] = code;
    end

    // A zero divisor finishes in one MDU cycle regardless of DIV_LAT.
    always_comb begin
        if (!bus.Funct3[2])   lat_m1 = MUL_M1;
        else if (bus.rs2_zero) lat_m1 = '0;
        else                   lat_m1 = DIV_M1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mdu_op_q <= 3'b000;
            start_q  <= 1'b0;
            kill_q   <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            kill_q  <= 1'b0;
            rsel_q  <= 1'b0;
            case (state)
                IDLE: if (launch) begin
                    state    <= BUSY;
                    mdu_op_q <= bus.Funct3;
                    cnt      <= lat_m1;
                    start_q  <= 1'b1;
                end
                BUSY: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        kill_q <= 1'b1;
                    end else if (cnt == '0) begin
                        state  <= DONE;
                        rsel_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    kill_q <= bus.flush;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Operation  = op;
    assign bus.illegal    = ill;
    assign bus.stall      = !reset && (launch || state == BUSY);
    assign bus.mdu_start  = start_q;
    assign bus.mdu_op     = mdu_op_q;
    assign bus.mdu_kill   = kill_q;
    assign bus.result_sel = rsel_q;
endmodule

// File: tb/tb_alu_mdu_controller.sv
// Bench for alu_mdu_controller: decode vectors, randomized decode against a
// rule-level model, and cycle-accurate MDU sequences (ENABLE_M=1 and =0).
module tb_alu_mdu_controller;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mdu_controller_if #(.OP_W(5)) ia ();
    alu_mdu_controller_if #(.OP_W(5)) ib ();

    assign ib.in_valid = ia.in_valid;
    assign ib.ALUOp    = ia.ALUOp;
    assign ib.Funct7   = ia.Funct7;
    assign ib.Funct3   = ia.Funct3;
    assign ib.rtype    = ia.rtype;
    assign ib.rs2_zero = ia.rs2_zero;
    assign ib.flush    = ia.flush;

    alu_mdu_controller #(.OP_W(5), .ENABLE_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT))
        dut_m (.clk(clk), .reset(reset), .bus(ia));
    alu_mdu_controller #(.OP_W(5), .ENABLE_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT))
        dut_nom (.clk(clk), .reset(reset), .bus(ib));

    typedef struct {
        logic [1:0] aop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       rt;
        logic [4:0] op;
        logic       ill;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rule-level decode reference: returns {illegal, code}.
    function automatic logic [5:0] ref_dec(input logic [1:0] aop, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic rt, input bit en_m);
        logic [4:0] br  [8] = '{5'b01000, 5'b01011, 5'b00010, 5'b00010,
                                5'b01001, 5'b01010, 5'b01100, 5'b01101};
        logic [4:0] alu [8] = '{5'b00010, 5'b00110, 5'b01110, 5'b10001,
                                5'b00011, 5'b00111, 5'b00001, 5'b00000};
        if (aop == 2'b00) return {1'b0, 5'b00010};
        if (aop == 2'b01) return {(f3 == 3'd2 || f3 == 3'd3), br[f3]};
        if (aop == 2'b11) return {1'b0, (f3 == 3'd0) ? 5'b00010 : 5'b01111};
        if (rt && f7 == 7'h01) return en_m ? {1'b0, 5'b10000} : {1'b1, 5'b00010};
        if (rt && f7 != 7'h00 && f7 != 7'h20) return {1'b1, 5'b00010};
        if (f3 == 3'd1 && f7 != 7'h00) return {1'b1, 5'b00010};
        if (f3 == 3'd5 && f7 == 7'h20) return {1'b0, 5'b00101};
        if (f3 == 3'd5 && f7 != 7'h00) return {1'b1, 5'b00010};
        if (f3 == 3'd0 && rt && f7 == 7'h20) return {1'b0, 5'b00100};
        return {1'b0, alu[f3]};
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic rz);
        if (!f3[2]) return MUL_LAT;
        return rz ? 1 : DIV_LAT;
    endfunction

    task automatic set_nop();
        ia.in_valid = 1'b0; ia.ALUOp = 2'b00; ia.Funct7 = 7'h00; ia.Funct3 = 3'b000;
        ia.rtype = 1'b0; ia.rs2_zero = 1'b0; ia.flush = 1'b0;
    endtask

    task automatic set_mop(input logic [2:0] f3, input logic rz);
        ia.in_valid = 1'b1; ia.ALUOp = 2'b10; ia.Funct7 = 7'h01; ia.Funct3 = f3;
        ia.rtype = 1'b1; ia.rs2_zero = rz; ia.flush = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_stall"}, ia.stall, 0);
        chk({tag, "_start"}, ia.mdu_start, 0);
        chk({tag, "_rsel"}, ia.result_sel, 0);
        chk({tag, "_kill"}, ia.mdu_kill, 0);
        nxt();
    endtask

    // Full M-op: launch cycle k=0 through DONE at k=lat+1; inputs left holding the M-op.
    task automatic run_mop(input logic [2:0] f3, input logic rz);
        int lat;
        lat = ref_lat(f3, rz);
        set_mop(f3, rz);
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk);
            chk("seq_stall", ia.stall, k <= lat);
            chk("seq_start", ia.mdu_start, k == 1);
            chk("seq_rsel", ia.result_sel, k == lat + 1);
            chk("seq_kill", ia.mdu_kill, 0);
            chk("nom_stall", ib.stall, 0);
            if (k == 0) begin
                chk("nom_op", ib.Operation, 5'b00010);
                chk("nom_ill", ib.illegal, 1);
            end
            if (k == 1) chk("seq_mdu_op", ia.mdu_op, f3);
            nxt();
        end
    endtask

    // Flush asserted in cycle kf (BUSY or DONE); kill must follow, no result.
    task automatic run_flush(input logic [2:0] f3, input logic rz, input int kf);
        int lat;
        lat = ref_lat(f3, rz);
        set_mop(f3, rz);
        for (int k = 0; k <= kf; k++) begin
            if (k == kf) ia.flush = 1'b1;
            @(negedge clk);
            chk("fl_stall", ia.stall, k <= lat);
            chk("fl_start", ia.mdu_start, k == 1);
            chk("fl_rsel", ia.result_sel, k == lat + 1);
            chk("fl_kill", ia.mdu_kill, 0);
            nxt();
        end
        set_nop();
        @(negedge clk);
        chk("fl_kill_pulse", ia.mdu_kill, 1);
        chk("fl_stall_after", ia.stall, 0);
        chk("fl_rsel_after", ia.result_sel, 0);
        nxt();
        chk_idle("fl_post");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] exp;
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};

        tbl[0]  = '{2'b10, 3'b000, 7'h20, 1'b0, 5'b00010, 1'b0};
        tbl[1]  = '{2'b10, 3'b000, 7'h20, 1'b1, 5'b00100, 1'b0};
        tbl[2]  = '{2'b01, 3'b110, 7'h00, 1'b0, 5'b01100, 1'b0};
        tbl[3]  = '{2'b01, 3'b010, 7'h00, 1'b0, 5'b00010, 1'b1};
        tbl[4]  = '{2'b10, 3'b000, 7'h01, 1'b1, 5'b10000, 1'b0};
        tbl[5]  = '{2'b10, 3'b101, 7'h20, 1'b1, 5'b00101, 1'b0};
        tbl[6]  = '{2'b10, 3'b101, 7'h20, 1'b0, 5'b00101, 1'b0};
        tbl[7]  = '{2'b10, 3'b011, 7'h00, 1'b1, 5'b10001, 1'b0};
        tbl[8]  = '{2'b11, 3'b010, 7'h00, 1'b0, 5'b01111, 1'b0};
        tbl[9]  = '{2'b11, 3'b000, 7'h00, 1'b0, 5'b00010, 1'b0};
        tbl[10] = '{2'b10, 3'b111, 7'h7F, 1'b1, 5'b00010, 1'b1};
        tbl[11] = '{2'b10, 3'b001, 7'h01, 1'b0, 5'b00010, 1'b1};
        tbl[12] = '{2'b00, 3'b111, 7'h7F, 1'b1, 5'b00010, 1'b0};
        tbl[13] = '{2'b01, 3'b101, 7'h00, 1'b0, 5'b01010, 1'b0};

        set_nop();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", ia.stall, 0);
        chk("rst_start", ia.mdu_start, 0);
        chk("rst_kill", ia.mdu_kill, 0);
        chk("rst_rsel", ia.result_sel, 0);
        chk("rst_mdu_op", ia.mdu_op, 0);
        nxt();
        reset = 1'b0;

        foreach (tbl[i]) begin
            ia.ALUOp = tbl[i].aop; ia.Funct3 = tbl[i].f3;
            ia.Funct7 = tbl[i].f7; ia.rtype = tbl[i].rt;
            #1;
            chk($sformatf("tbl%0d_op", i), ia.Operation, tbl[i].op);
            chk($sformatf("tbl%0d_ill", i), ia.illegal, tbl[i].ill);
        end

        for (int a = 0; a < 4; a++)
            for (int f = 0; f < 8; f++)
                for (int r = 0; r < 2; r++)
                    for (int s = 0; s < 4; s++) begin
                        ia.ALUOp = 2'(a); ia.Funct3 = 3'(f); ia.rtype = r[0]; ia.Funct7 = f7s[s];
                        #1;
                        exp = ref_dec(2'(a), 3'(f), f7s[s], r[0], 1'b1);
                        chk("sweep_op", ia.Operation, exp[4:0]);
                        chk("sweep_ill", ia.illegal, exp[5]);
                        exp = ref_dec(2'(a), 3'(f), f7s[s], r[0], 1'b0);
                        chk("sweep_nom_op", ib.Operation, exp[4:0]);
                        chk("sweep_nom_ill", ib.illegal, exp[5]);
                        chk("sweep_noval_stall", ia.stall, 0);
                    end

        for (int n = 0; n < 200; n++) begin
            ia.ALUOp = 2'($urandom); ia.Funct3 = 3'($urandom);
            ia.Funct7 = ($urandom_range(0, 1) == 1) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
            ia.rtype = 1'($urandom);
            #1;
            exp = ref_dec(ia.ALUOp, ia.Funct3, ia.Funct7, ia.rtype, 1'b1);
            chk("rnd_op", ia.Operation, exp[4:0]);
            chk("rnd_ill", ia.illegal, exp[5]);
        end
        set_nop();
        nxt();

        run_mop(3'b000, 1'b0);
        set_nop();
        chk_idle("mul_done");
        run_mop(3'b101, 1'b1);
        set_nop();
        chk_idle("divu_z");
        run_mop(3'b101, 1'b0);
        set_nop();
        chk_idle("divu");

        run_flush(3'b100, 1'b0, 5);
        run_mop(3'b000, 1'b0);
        set_nop();
        chk_idle("after_flush");
        run_flush(3'b000, 1'b0, MUL_LAT);
        run_flush(3'b011, 1'b0, MUL_LAT + 1);

        set_mop(3'b000, 1'b0);
        ia.flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", ia.stall, 0);
        nxt();
        set_nop();
        chk_idle("idle_flush");

        run_mop(3'b001, 1'b0);
        run_mop(3'b110, 1'b1);
        set_nop();
        chk_idle("b2b");

        for (int n = 0; n < 6; n++) begin
            run_mop(3'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                set_nop();
                chk_idle("rnd_gap");
            end
        end
        set_nop();
        chk_idle("rnd_end");

        set_mop(3'b100, 1'b0);
        repeat (3) nxt();
        @(negedge clk);
        chk("pre_rst_stall", ia.stall, 1);
        chk("pre_rst_op", ia.mdu_op, 3'b100);
        #2 reset = 1'b1;
        #1;
        chk("arst_stall", ia.stall, 0);
        chk("arst_start", ia.mdu_start, 0);
        chk("arst_kill", ia.mdu_kill, 0);
        chk("arst_rsel", ia.result_sel, 0);
        chk("arst_mdu_op", ia.mdu_op, 0);
        nxt();
        reset = 1'b0;
        set_nop();
        chk_idle("arst_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
